// File: rtl/collision_probe_pkg.sv
// Shared types for the collision probe: probe order, FSM states and hit-mask bit positions.
package collision_pkg;

  typedef enum logic [1:0] {
    PR_R = 2'd0,
    PR_L = 2'd1,
    PR_U = 2'd2,
    PR_D = 2'd3
  } probe_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MASK_R = 0;
  localparam int MASK_L = 1;
  localparam int MASK_U = 2;
  localparam int MASK_D = 3;

  function automatic logic [3:0] probe_bit(input probe_e p);
    logic [3:0] b;
    b = 4'b0000;
    case (p)
      PR_R:    b[MASK_R] = 1'b1;
      PR_L:    b[MASK_L] = 1'b1;
      PR_U:    b[MASK_U] = 1'b1;
      PR_D:    b[MASK_D] = 1'b1;
      default: b = 4'b0000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/collision_probe_if.sv
// Request/response and BRAM read port bundle of the collision probe.
interface collision_probe_if #(
  parameter int ADDR_W = 15
);
  logic              start_in;
  logic [15:0]       x_in;
  logic [15:0]       y_in;
  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic              rd_data_in;
  logic              busy_out;
  logic              done_out;
  logic [3:0]        hit_mask_out;

  modport slave (
    input  start_in, x_in, y_in, rd_data_in,
    output rd_en_out, rd_addr_out, busy_out, done_out, hit_mask_out
  );

  modport master (
    output start_in, x_in, y_in, rd_data_in,
    input  rd_en_out, rd_addr_out, busy_out, done_out, hit_mask_out
  );
endinterface

// File: rtl/collision_probe_rounder.sv
// Rounds 8.8 fixed-point x/y to the nearest cell (half rounds up); carry flags a result of 256.
module rounder (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [7:0]  o_x_c,
  output logic [7:0]  o_y_c,
  output logic        o_x_cy,
  output logic        o_y_cy
);
  assign {o_x_cy, o_x_c} = {1'b0, i_x[15:8]} + {8'd0, i_x[7]};
  assign {o_y_cy, o_y_c} = {1'b0, i_y[15:8]} + {8'd0, i_y[7]};
endmodule

// File: rtl/collision_probe.sv
// Probes the R/L/U/D neighbour cells of a ball position in the occupancy BRAM and returns a hit mask.
module collision_probe
  import collision_pkg::*;
#(
  parameter int GRID_W       = 160,
  parameter int GRID_H       = 120,
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  collision_probe_if.slave bus
);
  localparam int               CNT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(READ_LATENCY - 1);
  localparam logic [8:0]       GRID_W9    = 9'(GRID_W);
  localparam logic [8:0]       GRID_H9    = 9'(GRID_H);

  state_e                  r_state, w_state_nxt;
  probe_e                  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]        r_drain_cnt, w_drain_cnt_nxt;
  logic [15:0]             r_x, r_y;
  logic [7:0]              w_x_c, w_y_c;
  logic                    w_x_c_cy, w_y_c_cy;
  logic [8:0]              w_x_p1, w_y_p1;
  logic [7:0]              w_px, w_py;
  logic                    w_pcy, w_oob, w_accept;
  logic [ADDR_W-1:0]       w_addr;
  logic                    r_rd_en;
  logic [ADDR_W-1:0]       r_rd_addr;
  probe_e                  r_rd_idx;
  logic [READ_LATENCY-1:0] r_tag_v;
  probe_e                  r_tag_idx [READ_LATENCY];
  logic                    r_busy, r_done;
  logic [3:0]              r_hit_mask, w_mask_nxt;

  assign w_accept = (r_state == IDLE) && bus.start_in;
  assign w_x_p1   = {1'b0, r_x[15:8]} + 9'd1;
  assign w_y_p1   = {1'b0, r_y[15:8]} + 9'd1;

  rounder u_rounder (
    .i_x    (r_x),
    .i_y    (r_y),
    .o_x_c  (w_x_c),
    .o_y_c  (w_y_c),
    .o_x_cy (w_x_c_cy),
    .o_y_cy (w_y_c_cy)
  );

  // Position latch: taken only when a request is accepted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x <= 16'd0;
      r_y <= 16'd0;
    end else if (w_accept) begin
      r_x <= bus.x_in;
      r_y <= bus.y_in;
    end
  end

  // Cell for the current probe; any carried coordinate is out of bounds, never wrapped.
  always_comb begin
    w_px  = 8'd0;
    w_py  = 8'd0;
    w_pcy = 1'b0;
    case (r_idx)
      PR_R:    begin w_px = w_x_p1[7:0]; w_py = w_y_c;       w_pcy = w_x_p1[8] | w_y_c_cy; end
      PR_L:    begin w_px = r_x[15:8];   w_py = w_y_c;       w_pcy = w_y_c_cy;             end
      PR_U:    begin w_px = w_x_c;       w_py = w_y_p1[7:0]; w_pcy = w_x_c_cy | w_y_p1[8]; end
      PR_D:    begin w_px = w_x_c;       w_py = r_y[15:8];   w_pcy = w_x_c_cy;             end
      default: begin w_px = 8'd0;        w_py = 8'd0;        w_pcy = 1'b1;                 end
    endcase
    w_oob  = w_pcy | ({1'b0, w_px} >= GRID_W9) | ({1'b0, w_py} >= GRID_H9);
    w_addr = ADDR_W'(w_py) * ADDR_W'(GRID_W) + ADDR_W'(w_px);
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_idx       <= PR_R;
      r_drain_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // FSM next state: four issue slots, READ_LATENCY drain cycles, one done cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start_in) begin
          w_state_nxt = ISSUE;
          w_idx_nxt   = PR_R;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (r_idx == PR_D) begin
          w_state_nxt     = DRAIN;
          w_drain_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_idx_nxt = probe_e'(r_idx + 2'd1);
        end
      end
      DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read port: in-bounds probes strobe the BRAM, out-of-bounds slots stay quiet.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= {ADDR_W{1'b0}};
      r_rd_idx  <= PR_R;
    end else if (r_state == ISSUE) begin
      r_rd_en   <= !w_oob;
      r_rd_addr <= w_oob ? {ADDR_W{1'b0}} : w_addr;
      r_rd_idx  <= r_idx;
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= {ADDR_W{1'b0}};
      r_rd_idx  <= PR_R;
    end
  end

  // Tag pipeline aligns each returning bit with the probe that requested it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tag_v <= {READ_LATENCY{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) r_tag_idx[i] <= PR_R;
    end else begin
      r_tag_v[0]   <= r_rd_en;
      r_tag_idx[0] <= r_rd_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Mask update: cleared on acceptance, OOB bits set at issue, solid returns ORed in.
  always_comb begin
    w_mask_nxt = r_hit_mask;
    if (w_accept) begin
      w_mask_nxt = 4'b0000;
    end else begin
      if ((r_state == ISSUE) && w_oob) w_mask_nxt = w_mask_nxt | probe_bit(r_idx);
      else                             w_mask_nxt = w_mask_nxt;
      if (r_tag_v[READ_LATENCY-1] && bus.rd_data_in)
        w_mask_nxt = w_mask_nxt | probe_bit(r_tag_idx[READ_LATENCY-1]);
      else
        w_mask_nxt = w_mask_nxt;
    end
  end

  // Status outputs trail the FSM by one cycle so done coincides with the last return.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hit_mask <= 4'b0000;
    end else begin
      r_busy     <= (r_state != IDLE);
      r_done     <= (r_state == DONE);
      r_hit_mask <= w_mask_nxt;
    end
  end

  assign bus.rd_en_out    = r_rd_en;
  assign bus.rd_addr_out  = r_rd_addr;
  assign bus.busy_out     = r_busy;
  assign bus.done_out     = r_done;
  assign bus.hit_mask_out = r_hit_mask;

endmodule

// File: tb/tb_collision_probe.sv
// Self-checking bench: directed edge cases plus randomized probes against a cell-level reference model.
module tb_collision_probe;
  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int ADDR_W = 15;
  localparam int RL     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  collision_probe_if #(.ADDR_W(ADDR_W)) bus ();

  collision_probe #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W), .READ_LATENCY(RL)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  // BRAM model: two register stages; unrequested slots return random junk.
  bit   mem [0:32767];
  logic p0_v = 1'b0, p0_d = 1'b0, p1_v = 1'b0, p1_d = 1'b0, junk = 1'b0;
  logic force_one = 1'b0;
  always @(posedge clk) begin
    p0_v <= bus.rd_en_out;
    p0_d <= mem[bus.rd_addr_out];
    p1_v <= p0_v;
    p1_d <= p0_d;
    junk <= 1'($urandom);
  end
  assign bus.rd_data_in = force_one ? 1'b1 : (p1_v ? p1_d : junk);

  int n_pass  = 0;
  int n_total = 0;

  logic [17:0]       ov_en, ov_busy, ov_done;
  logic [ADDR_W-1:0] ov_addr [0:17];
  logic [3:0]        ov_mask [0:17];

  bit [3:0] exp_en;
  int       exp_addr [4];
  bit [3:0] exp_mask;

  // Reference: neighbour cells from plain integer arithmetic on the 8.8 inputs.
  function automatic void model_probe(input int x, input int y);
    int xi, yi, xc, yc;
    int px [4];
    int py [4];
    xi = x / 256;  yi = y / 256;
    xc = (x + 128) / 256;
    yc = (y + 128) / 256;
    px = '{xi + 1, xi, xc, xc};
    py = '{yc, yc, yi + 1, yi};
    exp_mask = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      exp_en[p]   = (px[p] < GRID_W) && (py[p] < GRID_H);
      exp_addr[p] = py[p] * GRID_W + px[p];
      if (!exp_en[p]) exp_mask[p] = 1'b1;
      else if (mem[exp_addr[p]]) exp_mask[p] = 1'b1;
    end
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
  endtask

  // Issue one request and record outputs in cycles 0..ncyc-1 (cycle 0 follows the accepting edge).
  task automatic do_probe(input logic [15:0] x, input logic [15:0] y, input int ncyc,
                          input bit hold, input bit noise);
    ov_en = '0; ov_busy = '0; ov_done = '0;
    @(negedge clk);
    bus.start_in = 1'b1; bus.x_in = x; bus.y_in = y;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ov_en[c] = bus.rd_en_out;  ov_busy[c] = bus.busy_out;  ov_done[c] = bus.done_out;
      ov_addr[c] = bus.rd_addr_out;  ov_mask[c] = bus.hit_mask_out;
      if (hold && c < ncyc - 1) bus.start_in = 1'b1;
      else if (noise && c <= 6) begin
        bus.start_in = 1'($urandom); bus.x_in = 16'($urandom); bus.y_in = 16'($urandom);
      end else bus.start_in = 1'b0;
    end
    bus.start_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.rd_en_out, bus.rd_addr_out, bus.busy_out, bus.done_out, bus.hit_mask_out} !== 22'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.rd_en_out, bus.rd_addr_out, bus.busy_out, bus.done_out, bus.hit_mask_out});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.rd_en_out, bus.busy_out, bus.done_out, bus.hit_mask_out} !== 7'd0)
      $display("FAIL idle_after_reset: got %h expected 0",
               {bus.rd_en_out, bus.busy_out, bus.done_out, bus.hit_mask_out});
    else n_pass++;
  endtask

  task automatic test_free_space();
    logic [ADDR_W-1:0] want [4];
    want = '{15'd5137, 15'd5136, 15'd5297, 15'd5137};
    clear_map();
    do_probe(16'h1080, 16'h2040, 10, 1'b0, 1'b0);
    n_total++;
    if (ov_en !== 18'h0001E) $display("FAIL free_rd_en: got %h expected 0001e", ov_en);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (ov_addr[k+1] !== want[k])
        $display("FAIL free_addr%0d: got %0d expected %0d", k, ov_addr[k+1], want[k]);
      else n_pass++;
    end
    n_total++;
    if (ov_busy !== 18'h000FE) $display("FAIL free_busy: got %h expected 000fe", ov_busy);
    else n_pass++;
    n_total++;
    if (ov_done !== 18'h00080) $display("FAIL free_done: got %h expected 00080", ov_done);
    else n_pass++;
    n_total++;
    if (ov_mask[7] !== 4'b0000) $display("FAIL free_mask: got %b expected 0000", ov_mask[7]);
    else n_pass++;
  endtask

  task automatic test_single_wall();
    clear_map();
    mem[5136] = 1'b1;
    do_probe(16'h1080, 16'h2040, 10, 1'b0, 1'b0);
    n_total++;
    if (ov_mask[7] !== 4'b0010) $display("FAIL wall_mask: got %b expected 0010", ov_mask[7]);
    else n_pass++;
    n_total++;
    if (ov_mask[9] !== 4'b0010) $display("FAIL wall_mask_held: got %b expected 0010", ov_mask[9]);
    else n_pass++;
  endtask

  task automatic test_right_edge();
    clear_map();
    do_probe(16'h9F00, 16'h1000, 10, 1'b0, 1'b0);
    n_total++;
    if (ov_en !== 18'h0001C) $display("FAIL edge_rd_en: got %h expected 0001c", ov_en);
    else n_pass++;
    n_total++;
    if (ov_mask[7] !== 4'b0001) $display("FAIL edge_mask: got %b expected 0001", ov_mask[7]);
    else n_pass++;
  endtask

  task automatic test_carry_wrap();
    clear_map();
    do_probe(16'hFF80, 16'h0000, 10, 1'b0, 1'b0);
    n_total++;
    if (ov_en !== 18'h00000) $display("FAIL carry_rd_en: got %h expected 00000", ov_en);
    else n_pass++;
    n_total++;
    if (ov_mask[7] !== 4'b1111) $display("FAIL carry_mask: got %b expected 1111", ov_mask[7]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_map();
    do_probe(16'h1080, 16'h2040, 16, 1'b1, 1'b0);
    n_total++;
    if (ov_done !== 18'h08080) $display("FAIL hold_done: got %h expected 08080", ov_done);
    else n_pass++;
    n_total++;
    if (ov_busy !== 18'h0FEFE) $display("FAIL hold_busy: got %h expected 0fefe", ov_busy);
    else n_pass++;
    n_total++;
    if (ov_en !== 18'h01E1E) $display("FAIL hold_rd_en: got %h expected 01e1e", ov_en);
    else n_pass++;
  endtask

  task automatic test_reset_mid_probe();
    clear_map();
    force_one = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b1; bus.x_in = 16'h1080; bus.y_in = 16'h2040;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.rd_en_out, bus.rd_addr_out, bus.busy_out, bus.done_out, bus.hit_mask_out} !== 22'd0)
      $display("FAIL midreset_outputs: got %h expected 0",
               {bus.rd_en_out, bus.rd_addr_out, bus.busy_out, bus.done_out, bus.hit_mask_out});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({bus.busy_out, bus.done_out, bus.hit_mask_out} !== 6'd0)
      $display("FAIL midreset_discard: got %h expected 0",
               {bus.busy_out, bus.done_out, bus.hit_mask_out});
    else n_pass++;
    force_one = 1'b0;
    repeat (RL) @(negedge clk);
    do_probe(16'h1080, 16'h2040, 10, 1'b0, 1'b0);
    n_total++;
    if (ov_done !== 18'h00080) $display("FAIL midreset_done: got %h expected 00080", ov_done);
    else n_pass++;
    n_total++;
    if (ov_mask[7] !== 4'b0000) $display("FAIL midreset_mask: got %b expected 0000", ov_mask[7]);
    else n_pass++;
  endtask

  task automatic test_random();
    int xi, yi, x, y;
    for (int it = 0; it < 40; it++) begin
      if (it % 10 == 0)
        for (int i = 0; i < 32768; i++) mem[i] = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0:       xi = $urandom_range(0, 255);
        1:       xi = $urandom_range(157, 160);
        2:       xi = 255;
        default: xi = $urandom_range(0, 159);
      endcase
      case ($urandom_range(0, 4))
        0:       yi = $urandom_range(0, 255);
        1:       yi = $urandom_range(117, 120);
        2:       yi = 255;
        default: yi = $urandom_range(0, 119);
      endcase
      x = xi * 256 + $urandom_range(0, 255);
      y = yi * 256 + $urandom_range(0, 255);
      model_probe(x, y);
      do_probe(16'(x), 16'(y), 10, 1'b0, 1'b1);
      n_total++;
      if (ov_en !== (18'(exp_en) << 1))
        $display("FAIL rand%0d_rd_en: got %h expected %h", it, ov_en, 18'(exp_en) << 1);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
        if (exp_en[k]) begin
          n_total++;
          if (ov_addr[k+1] !== 15'(exp_addr[k]))
            $display("FAIL rand%0d_addr%0d: got %0d expected %0d", it, k, ov_addr[k+1], exp_addr[k]);
          else n_pass++;
        end
      end
      n_total++;
      if (ov_busy !== 18'h000FE) $display("FAIL rand%0d_busy: got %h expected 000fe", it, ov_busy);
      else n_pass++;
      n_total++;
      if (ov_done !== 18'h00080) $display("FAIL rand%0d_done: got %h expected 00080", it, ov_done);
      else n_pass++;
      n_total++;
      if (ov_mask[7] !== exp_mask)
        $display("FAIL rand%0d_mask: got %b expected %b", it, ov_mask[7], exp_mask);
      else n_pass++;
      n_total++;
      if (ov_mask[9] !== exp_mask)
        $display("FAIL rand%0d_mask_held: got %b expected %b", it, ov_mask[9], exp_mask);
      else n_pass++;
    end
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.x_in     = 16'h0000;
    bus.y_in     = 16'h0000;
    test_reset();
    test_free_space();
    test_single_wall();
    test_right_edge();
    test_carry_wrap();
    test_back_to_back();
    test_reset_mid_probe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
